// File: rtl/adc_scan_reader.sv
// adc_scan_reader: round-robin SPI ADC channel scanner with optional per-channel averaging
// Ports: clk, rst_n (async, active low); run (level, scan enable); adc_dout (ADC serial data out);
//   sclk / cs_n / din (generated ADC serial clock, chip select, channel address out);
//   samp_data / samp_ch / samp_valid (tagged sample with one-clk strobe); busy (FSM not idle).
module adc_scan_reader #(
  parameter int SYS_DIV    = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 3,
  parameter int NUM_CH     = 4,
  parameter int AVG_LOG2   = 0,
  parameter int FRAME_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              adc_dout,
  output logic              sclk,
  output logic              cs_n,
  output logic              din,
  output logic [DATA_W-1:0] samp_data,
  output logic [ADDR_W-1:0] samp_ch,
  output logic              samp_valid,
  output logic              busy
);
  localparam int DIV_W = SYS_DIV > 1 ? $clog2(SYS_DIV) : 1;
  localparam int BIT_W = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W = FRAME_GAP > 1 ? $clog2(FRAME_GAP) : 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  typedef enum logic [1:0] {IDLE, GAP, XFER, DONE} state_t;
  state_t state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [FRAME_BITS-1:0] din_sr, frame_w;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] ch_ptr, ch_nxt, addr_tx;
  logic prime, gap_end, half_end, bit_end, full, start;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [ACC_W-1:0] sel_acc, sum;
  logic [CNT_W-1:0] sel_cnt;
  assign busy = state != IDLE;
  assign gap_end = gap_cnt == GAP_W'(FRAME_GAP - 1);
  assign half_end = div_cnt == DIV_W'(SYS_DIV - 1);
  assign bit_end = bit_cnt == BIT_W'(FRAME_BITS - 1);
  assign start = state == GAP && gap_end;
  // ch_ptr is the channel whose conversion is read this frame; the address sent selects the next one
  assign ch_nxt = (ch_ptr == ADDR_W'(NUM_CH - 1)) ? '0 : ch_ptr + 1'b1;
  assign addr_tx = prime ? '0 : ch_nxt;
  // address occupies frame bits 2..ADDR_W+1, MSB first, everything else zero
  assign frame_w = {{(FRAME_BITS - ADDR_W){1'b0}}, addr_tx} << (FRAME_BITS - 2 - ADDR_W);
  assign sum = sel_acc + ACC_W'(shreg);
  assign full = sel_cnt == CNT_W'((1 << AVG_LOG2) - 1);
  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ADDR_W'(i) == ch_ptr) begin
        sel_acc = acc[i];
        sel_cnt = cnt[i];
      end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = run ? GAP : IDLE;
      GAP:     state_d = gap_end ? XFER : GAP;
      XFER:    state_d = (sclk && half_end && bit_end) ? DONE : XFER;
      default: state_d = run ? GAP : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      sclk       <= 1'b1;
      cs_n       <= 1'b1;
      din        <= 1'b0;
      din_sr     <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ch_ptr     <= '0;
      prime      <= 1'b1;
      samp_data  <= '0;
      samp_ch    <= '0;
      samp_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state      <= state_d;
      samp_valid <= 1'b0;
      gap_cnt    <= (state == GAP && !gap_end) ? gap_cnt + 1'b1 : '0;
      div_cnt    <= (state == XFER && !half_end) ? div_cnt + 1'b1 : '0;
      if (start) begin
        cs_n    <= 1'b0;
        sclk    <= 1'b0;
        din     <= frame_w[FRAME_BITS-1];
        din_sr  <= frame_w << 1;
        bit_cnt <= '0;
      end else if (state == XFER && half_end) begin
        if (!sclk) begin
          sclk <= 1'b1;
          if (bit_cnt >= BIT_W'(FRAME_BITS - DATA_W))
            shreg <= {shreg[DATA_W-2:0], adc_dout};
        end else if (bit_end) begin
          cs_n <= 1'b1;
        end else begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          din     <= din_sr[FRAME_BITS-1];
          din_sr  <= din_sr << 1;
        end
      end
      if (state == DONE) begin
        prime  <= !run;
        ch_ptr <= (!run || prime) ? '0 : ch_nxt;
        if (!prime && full) begin
          samp_valid <= 1'b1;
          samp_data  <= DATA_W'(sum >> AVG_LOG2);
          samp_ch    <= ch_ptr;
        end
        // leaving for IDLE drops partial averages so a restart begins clean
        for (int i = 0; i < NUM_CH; i++)
          if (!run) begin
            acc[i] <= '0;
            cnt[i] <= '0;
          end else if (!prime && ADDR_W'(i) == ch_ptr) begin
            acc[i] <= full ? '0 : sum;
            cnt[i] <= full ? '0 : cnt[i] + 1'b1;
          end
      end
    end
endmodule

// File: tb/tb_adc_scan_reader.sv
// tb_adc_scan_reader: scoreboard bench for adc_scan_reader with three parameter sets
module tb_adc_scan_reader;
  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    int          cyc;
  } exp_t;
  logic clk = 0;
  logic rst_n;
  logic [2:0] run;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [11:0] tab [4] = '{12'd10, 12'd11, 12'd12, 12'd14};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // d0: defaults; d1: NUM_CH=2 AVG_LOG2=2; d2: SYS_DIV=1 NUM_CH=1 FRAME_GAP=1
  for (genvar g = 0; g < 3; g++) begin : trk
    localparam int SD = (g == 2) ? 1 : 2;
    localparam int NC = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    localparam int AL = (g == 1) ? 2 : 0;
    localparam int FG = (g == 2) ? 1 : 4;
    logic sclk, cs_n, din, sv, busy, adc_dout;
    logic [11:0] sd;
    logic [2:0] sch;
    exp_t q[$];
    exp_t e;
    logic prime, prev_cs, prev_sclk, last_din;
    logic [2:0] rd, adc_addr;
    logic [15:0] word, dw;
    int rises, low_len, conv0, last_v;
    int cnt [2];
    adc_scan_reader #(.SYS_DIV(SD), .NUM_CH(NC), .AVG_LOG2(AL), .FRAME_GAP(FG)) dut (
      .clk(clk), .rst_n(rst_n), .run(run[g]), .adc_dout(adc_dout), .sclk(sclk), .cs_n(cs_n),
      .din(din), .samp_data(sd), .samp_ch(sch), .samp_valid(sv), .busy(busy));
    initial begin
      conv0 = 0;
      last_v = 0;
      adc_dout = 0;
    end
    // ADC model plus frame tracker: drives DOUT, decodes DIN, queues expected samples
    always @(negedge clk) begin
      if (!rst_n) begin
        prime = 1;
        prev_cs = 1;
        prev_sclk = 1;
        rd = 0;
        adc_addr = 0;
        cnt[0] = 0;
        cnt[1] = 0;
        adc_dout = 0;
        q.delete();
      end else begin
        if (prev_cs && !cs_n) begin
          rises = 0;
          low_len = 0;
          dw = '0;
          word = {4'h0, (g == 0) ? 12'hA00 + 12'(adc_addr) : (g == 2) ? 12'hFFF :
                 (adc_addr == 0) ? tab[conv0 % 4] : 12'd200};
          if (g == 1 && adc_addr == 0) conv0++;
        end
        if (!cs_n) begin
          low_len++;
          if (sclk && !prev_sclk) rises++;
          if (!sclk) adc_dout = word[15 - rises];
          else begin
            dw[16 - rises] = din;
            if (SD > 1 && prev_sclk) chk($sformatf("d%0d din_stable", g), din, last_din);
          end
        end else begin
          chk($sformatf("d%0d idle_sclk", g), sclk, 1);
          chk($sformatf("d%0d idle_din", g), din, 0);
        end
        if (!prev_cs && cs_n) begin
          chk($sformatf("d%0d cs_low_len", g), low_len, 2 * SD * 16);
          chk($sformatf("d%0d din_word", g), dw, (prime ? 0 : (rd + 1) % NC) << 11);
          adc_addr = dw[13:11];
          if (!prime) begin
            if (AL == 0) q.push_back('{ch: rd, data: (g == 0) ? 12'hA00 + 12'(rd) : 12'hFFF, cyc: cyc + 1});
            else begin
              cnt[rd[0]]++;
              if (cnt[rd[0]] == 4) begin
                q.push_back('{ch: rd, data: (rd == 0) ? 12'd11 : 12'd200, cyc: cyc + 1});
                cnt[rd[0]] = 0;
              end
            end
          end
          rd = prime ? 3'd0 : 3'((rd + 1) % NC);
          prime = !run[g];
          if (prime) begin
            rd = 0;
            cnt[0] = 0;
            cnt[1] = 0;
          end
        end
        prev_cs = cs_n;
        prev_sclk = sclk;
        last_din = din;
      end
    end
    always @(negedge clk)
      if (rst_n && sv) begin
        chk($sformatf("d%0d sample_expected", g), q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("d%0d samp_ch", g), sch, e.ch);
          chk($sformatf("d%0d samp_data", g), sd, e.data);
          chk($sformatf("d%0d samp_cycle", g), cyc, e.cyc);
        end
        if (g == 2 && last_v > 0) chk("d2 sample_period", cyc - last_v, 34);
        last_v = cyc;
      end
  end
  initial begin
    bit found;
    rst_n = 0;
    run = 0;
    repeat (3) @(negedge clk);
    chk("rst cs_n", trk[0].cs_n, 1);
    chk("rst sclk", trk[0].sclk, 1);
    chk("rst din", trk[0].din, 0);
    chk("rst busy", trk[0].busy, 0);
    chk("rst valid", trk[0].sv, 0);
    chk("rst data", trk[0].sd, 0);
    chk("rst ch", trk[0].sch, 0);
    rst_n = 1;
    @(posedge clk);
    #1 run = 3'b111;
    repeat (1250) @(negedge clk);
    @(posedge clk);
    #1 run = 3'b001;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      found = !trk[0].cs_n && trk[0].rd == 2 && trk[0].low_len > 10;
    end
    chk("t4 reach_ch2_frame", found, 1);
    @(posedge clk);
    #1 run = 3'b000;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = trk[0].cs_n;
    end
    chk("t4 frame_end", found, 1);
    chk("t4 busy_in_done", trk[0].busy, 1);
    @(negedge clk);
    chk("t4 busy_after_done", trk[0].busy, 0);
    repeat (20) @(negedge clk);
    chk("t4 busy_idle", trk[0].busy, 0);
    chk("t4 cs_idle", trk[0].cs_n, 1);
    @(posedge clk);
    #1 run = 3'b001;
    repeat (300) @(negedge clk);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = !trk[0].cs_n && trk[0].low_len > 20;
    end
    chk("t5 reach_xfer", found, 1);
    rst_n = 0;
    #1;
    chk("t5 cs_n", trk[0].cs_n, 1);
    chk("t5 sclk", trk[0].sclk, 1);
    chk("t5 din", trk[0].din, 0);
    chk("t5 busy", trk[0].busy, 0);
    chk("t5 valid", trk[0].sv, 0);
    chk("t5 data", trk[0].sd, 0);
    chk("t5 ch", trk[0].sch, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (300) @(negedge clk);
    @(posedge clk);
    #1 run = 3'b000;
    repeat (150) @(negedge clk);
    chk("end d0 queue", trk[0].q.size(), 0);
    chk("end d1 queue", trk[1].q.size(), 0);
    chk("end d2 queue", trk[2].q.size(), 0);
    chk("end d0 busy", trk[0].busy, 0);
    chk("end d1 busy", trk[1].busy, 0);
    chk("end d2 busy", trk[2].busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
